pair_judge: RTL and testbench
=============================

// Module: pair_judge
// PURPOSE
//   Consumer of the square selections produced by the cursor/selection steps of the
//   8-square colour-matching game. Accepts committed square indices one at a time and
//   groups them into pairs. Looks up each square's colour and judges match or miss.
//   Keeps matched squares face up. Shows a missed pair for a fixed time, then hides it.
//   Reports game completion and an attempt count to the display/score logic.
// PARAMETERS
//   REVEAL_CYCLES  25_000_000    cycles a missed pair stays shown (1 s at 25 MHz); must be >= 1
//   COLOR_MAP      24'o32103210  3-bit colour per square; square i = COLOR_MAP[3*i+:3]
// PORTS
//   clk25MHz      in   1  system clock, 25 MHz
//   rst           in   1  synchronous reset, active-high
//   sel_valid     in   1  one-cycle commit strobe for sel_idx
//   sel_idx       in   3  committed square index 0..7
//   busy          out  1  high in COMPARE, SHOW, DONE; upstream holds its commits
//   reveal_mask   out  8  squares face up in the current attempt (not yet matched)
//   matched_mask  out  8  squares permanently matched
//   match_pulse   out  1  one-cycle strobe: pair matched
//   miss_pulse    out  1  one-cycle strobe: pair missed
//   err_pulse     out  1  one-cycle strobe: illegal selection rejected
//   attempts      out  8  judged pairs, saturates at 255
//   game_done     out  1  all 8 squares matched
// BEHAVIOUR
//   Reset (takes effect at the next edge, from any state, including mid-SHOW):
//     state=FIRST, all masks=0, all pulses=0, attempts=0, game_done=0, timer=0.
//   All outputs are registered. Each pulse is high for exactly one cycle.
//   FIRST:
//     - sel_valid with matched_mask[sel_idx]=1 -> err_pulse; stay in FIRST.
//     - otherwise: first_q<=sel_idx; reveal_mask[sel_idx]<=1; go to WAIT2.
//   WAIT2:
//     - sel_valid with sel_idx==first_q or matched -> err_pulse; stay in WAIT2.
//     - otherwise: second_q<=sel_idx; set its reveal bit; go to COMPARE.
//   COMPARE (exactly one cycle; sel_valid ignored, no err):
//     - attempts += 1 (saturating).
//     - Colours equal: matched_mask |= both bits; clear both reveal bits; match_pulse.
//       Go to DONE if the new matched_mask==8'hFF, else go to FIRST.
//     - Colours differ: miss_pulse; timer<=REVEAL_CYCLES-1; go to SHOW.
//   SHOW: sel_valid ignored silently.
//     - While timer!=0: timer decrements.
//     - At timer==0: clear both reveal bits; go to FIRST.
//     - reveal_mask holds the pair for exactly REVEAL_CYCLES cycles after the COMPARE cycle.
//   DONE: game_done=1; sel_valid ignored; left only by rst.
//   Latency: second commit sampled at edge N -> COMPARE during cycle N+1 ->
//     match/miss pulse and updated masks/attempts visible after edge N+2.
//   sel_valid is sampled only in FIRST and WAIT2. There is no queueing.
//   A COLOR_MAP with a colour not appearing exactly twice is legal. In that case
//     game_done never asserts.
// TESTING (REVEAL_CYCLES=4, default COLOR_MAP)
//   1. Reset:
//      assert rst 1 cycle -> masks 00, attempts 0, busy 0, game_done 0, no pulses.
//   2. Match:
//      sel 0 then sel 4 -> match_pulse 1 cycle at N+2, matched_mask=8'h11,
//      reveal_mask=8'h00, attempts=1.
//   3. Miss:
//      sel 0 then sel 1 -> miss_pulse; reveal_mask=8'h03 for exactly 4 cycles, then 8'h00.
//      A sel_valid during SHOW changes nothing. attempts=1.
//   4. Illegal selections:
//      sel 2, sel 2 -> err_pulse, reveal_mask stays 8'h04, state WAIT2.
//      After matching 0/4, sel 4 in FIRST -> err_pulse.
//   5. Full game:
//      pairs (0,4) (1,5) (2,6) (3,7) -> matched_mask=8'hFF, game_done=1, attempts=4.
//      Later sel_valid is ignored.
//   6. Reset mid-SHOW:
//      rst during SHOW -> next cycle all masks 0, state FIRST, attempts 0,
//      no stale hide event.

Source files
------------

// File: rtl/pair_judge.sv
// Pair judge for the 8-square colour-matching game: pairs committed selections,
// judges colour match/miss, keeps matches face up and hides misses after a delay.
module pair_judge #(
    parameter int unsigned REVEAL_CYCLES = 25_000_000,
    parameter logic [23:0] COLOR_MAP     = 24'o32103210
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [2:0] sel_idx,
    output logic       busy,
    output logic [7:0] reveal_mask,
    output logic [7:0] matched_mask,
    output logic       match_pulse,
    output logic       miss_pulse,
    output logic       err_pulse,
    output logic [7:0] attempts,
    output logic       game_done
);

    localparam int TW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    typedef enum logic [2:0] {
        FIRST   = 3'd0,
        WAIT2   = 3'd1,
        COMPARE = 3'd2,
        SHOW    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      first_q, first_d;
    logic [2:0]      second_q, second_d;
    logic [7:0]      reveal_q, reveal_d;
    logic [7:0]      matched_q, matched_d;
    logic [7:0]      attempts_q, attempts_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            match_q, match_d;
    logic            miss_q, miss_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [7:0]      pair_mask;
    logic            same_colour;

    function automatic logic [2:0] colour_of(input logic [2:0] idx);
        logic [4:0] base;
        base = 5'(idx) * 5'd3;
        return COLOR_MAP[base +: 3];
    endfunction

    assign pair_mask   = (8'b1 << first_q) | (8'b1 << second_q);
    assign same_colour = (colour_of(first_q) == colour_of(second_q));

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        second_d   = second_q;
        reveal_d   = reveal_q;
        matched_d  = matched_q;
        attempts_d = attempts_q;
        timer_d    = timer_q;
        done_d     = done_q;
        match_d    = 1'b0;
        miss_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            FIRST: begin
                if (sel_valid) begin
                    if (matched_q[sel_idx]) begin
                        err_d = 1'b1;
                    end else begin
                        first_d           = sel_idx;
                        reveal_d[sel_idx] = 1'b1;
                        state_d           = WAIT2;
                    end
                end
            end
            WAIT2: begin
                if (sel_valid) begin
                    if (sel_idx == first_q || matched_q[sel_idx]) begin
                        err_d = 1'b1;
                    end else begin
                        second_d          = sel_idx;
                        reveal_d[sel_idx] = 1'b1;
                        state_d           = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (attempts_q != 8'hFF) begin
                    attempts_d = attempts_q + 8'd1;
                end
                if (same_colour) begin
                    matched_d = matched_q | pair_mask;
                    reveal_d  = reveal_q & ~pair_mask;
                    match_d   = 1'b1;
                    if (matched_d == 8'hFF) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FIRST;
                    end
                end else begin
                    miss_d  = 1'b1;
                    timer_d = TW'(REVEAL_CYCLES - 1);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // Missed pair stays visible until the countdown expires.
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    reveal_d = reveal_q & ~pair_mask;
                    state_d  = FIRST;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = FIRST;
            end
        endcase
        busy_d = (state_d == COMPARE) || (state_d == SHOW) ||
                 (state_d == DONE);
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            state_q    <= FIRST;
            first_q    <= 3'd0;
            second_q   <= 3'd0;
            reveal_q   <= 8'h00;
            matched_q  <= 8'h00;
            attempts_q <= 8'h00;
            timer_q    <= '0;
            match_q    <= 1'b0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            second_q   <= second_d;
            reveal_q   <= reveal_d;
            matched_q  <= matched_d;
            attempts_q <= attempts_d;
            timer_q    <= timer_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign reveal_mask  = reveal_q;
    assign matched_mask = matched_q;
    assign match_pulse  = match_q;
    assign miss_pulse   = miss_q;
    assign err_pulse    = err_q;
    assign attempts     = attempts_q;
    assign game_done    = done_q;

endmodule

// File: tb/tb_pair_judge.sv
// Scoreboard bench for pair_judge: stimulus queues expected pulse events,
// a negedge monitor pops and compares them; direct checks cover timing.
module tb_pair_judge;

    logic       clk;
    logic       rst;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic       busy;
    logic [7:0] reveal_mask;
    logic [7:0] matched_mask;
    logic       match_pulse;
    logic       miss_pulse;
    logic       err_pulse;
    logic [7:0] attempts;
    logic       game_done;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] matched;
        logic [7:0] reveal;
        logic [7:0] att;
    } ev_t;

    localparam logic [2:0] K_MATCH = 3'b100;
    localparam logic [2:0] K_MISS  = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    pair_judge #(
        .REVEAL_CYCLES(4),
        .COLOR_MAP(24'o32103210)
    ) dut (
        .clk25MHz    (clk),
        .rst         (rst),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .busy        (busy),
        .reveal_mask (reveal_mask),
        .matched_mask(matched_mask),
        .match_pulse (match_pulse),
        .miss_pulse  (miss_pulse),
        .err_pulse   (err_pulse),
        .attempts    (attempts),
        .game_done   (game_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [7:0] m,
                             input logic [7:0] r, input logic [7:0] a);
        ev_t e;
        e.kind    = k;
        e.matched = m;
        e.reveal  = r;
        e.att     = a;
        exp_q.push_back(e);
    endtask

    task automatic commit(input logic [2:0] idx);
        @(posedge clk);
        #1;
        sel_valid = 1'b1;
        sel_idx   = idx;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: every pulse must correspond to the next queued event.
    always @(negedge clk) begin
        if (!rst && (match_pulse || miss_pulse || err_pulse)) begin
            ev_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse",
                    {29'd0, match_pulse, miss_pulse, err_pulse}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind", {29'd0, match_pulse, miss_pulse, err_pulse},
                    {29'd0, e.kind});
                chk("ev_matched", {24'd0, matched_mask}, {24'd0, e.matched});
                chk("ev_reveal", {24'd0, reveal_mask}, {24'd0, e.reveal});
                chk("ev_attempts", {24'd0, attempts}, {24'd0, e.att});
            end
        end
    end

    task automatic do_match(input logic [2:0] a, input logic [2:0] b,
                            input logic [7:0] m, input logic [7:0] att);
        expect_ev(K_MATCH, m, 8'h00, att);
        commit(a);
        commit(b);
        idle(2);
        chk("match_matched", {24'd0, matched_mask}, {24'd0, m});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_reveal"}, {24'd0, reveal_mask}, 32'h0);
        chk({tag, "_matched"}, {24'd0, matched_mask}, 32'h0);
        chk({tag, "_attempts"}, {24'd0, attempts}, 32'h0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'h0);
        chk({tag, "_done"}, {31'd0, game_done}, 32'h0);
        chk({tag, "_pulses"}, {29'd0, match_pulse, miss_pulse, err_pulse},
            32'h0);
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        idle(2);
        rst = 1'b0;
        idle(1);
        check_reset_state("reset");

        // Miss (0,1): pair shown for exactly 4 cycles, SHOW ignores input.
        expect_ev(K_MISS, 8'h00, 8'h03, 8'd1);
        commit(3'd0);
        commit(3'd1);
        chk("miss_busy_compare", {31'd0, busy}, 32'h1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                sel_valid = 1'b1;
                sel_idx   = 3'd5;
            end else begin
                sel_valid = 1'b0;
            end
            if (reveal_mask == 8'h03) cnt++;
        end
        chk("miss_reveal_cycles", cnt, 32'd4);
        chk("miss_reveal_after", {24'd0, reveal_mask}, 32'h0);
        chk("miss_busy_after", {31'd0, busy}, 32'h0);
        chk("miss_attempts", {24'd0, attempts}, 32'd1);

        // Match (0,4) with pulse latency checks.
        expect_ev(K_MATCH, 8'h11, 8'h00, 8'd2);
        commit(3'd0);
        commit(3'd4);
        chk("match_lat_n1_pulse", {31'd0, match_pulse}, 32'h0);
        chk("match_lat_n1_busy", {31'd0, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("match_lat_n2_pulse", {31'd0, match_pulse}, 32'h1);
        chk("match_reveal", {24'd0, reveal_mask}, 32'h0);
        @(posedge clk);
        #1;
        chk("match_pulse_width", {31'd0, match_pulse}, 32'h0);

        // Illegal selections.
        expect_ev(K_ERR, 8'h11, 8'h00, 8'd2);
        commit(3'd4);
        idle(1);
        expect_ev(K_ERR, 8'h11, 8'h04, 8'd2);
        commit(3'd2);
        commit(3'd2);
        idle(1);
        chk("err_reveal_hold", {24'd0, reveal_mask}, 32'h04);
        chk("err_busy_wait2", {31'd0, busy}, 32'h0);
        expect_ev(K_MATCH, 8'h55, 8'h00, 8'd3);
        commit(3'd6);
        idle(2);
        chk("match26_matched", {24'd0, matched_mask}, 32'h55);

        // Reset in the middle of SHOW.
        expect_ev(K_MISS, 8'h55, 8'h0A, 8'd4);
        commit(3'd1);
        commit(3'd3);
        idle(3);
        chk("show_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_state("midshow");
        idle(8);
        chk("midshow_no_stale", {24'd0, reveal_mask}, 32'h0);
        chk("midshow_idle_busy", {31'd0, busy}, 32'h0);

        // Full game from fresh state.
        do_match(3'd0, 3'd4, 8'h11, 8'd1);
        do_match(3'd1, 3'd5, 8'h33, 8'd2);
        do_match(3'd2, 3'd6, 8'h77, 8'd3);
        do_match(3'd3, 3'd7, 8'hFF, 8'd4);
        chk("game_done", {31'd0, game_done}, 32'h1);
        chk("game_busy", {31'd0, busy}, 32'h1);
        chk("game_attempts", {24'd0, attempts}, 32'd4);
        commit(3'd0);
        commit(3'd1);
        idle(3);
        chk("done_ignore_matched", {24'd0, matched_mask}, 32'hFF);
        chk("done_ignore_reveal", {24'd0, reveal_mask}, 32'h0);
        chk("done_ignore_attempts", {24'd0, attempts}, 32'd4);
        chk("done_hold", {31'd0, game_done}, 32'h1);

        idle(2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
